// File: rtl/pps_period_meter.sv
// pps_period_meter: counts CLK_SYS cycles between rising edges of an external
// pulse and publishes each period, its signed error against NOMINAL and an
// in-tolerance flag through a valid/ack handshake. Flags loss of the pulse.
module pps_period_meter #(
  parameter int unsigned NOMINAL = 20_000_000,
  parameter int unsigned TOL     = 1000,
  parameter int unsigned TIMEOUT = 30_000_000
) (
  input  logic        CLK_SYS,
  input  logic        CLK_RST,
  input  logic        pps_in,
  input  logic        period_ack,
  output logic [31:0] period,
  output logic [31:0] freq_err,
  output logic        in_tol,
  output logic        period_valid,
  output logic        overrun,
  output logic        pps_lost
);

  localparam logic [31:0] TimeoutM1 = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StAcq,
    StMeas,
    StLost
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] period_q, period_d;
  logic [31:0] freq_err_q, freq_err_d;
  logic        in_tol_q, in_tol_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        lost_q, lost_d;

  logic        pps_edge;
  logic        capture;
  logic        at_timeout;
  logic [31:0] cnt_plus1;
  logic [32:0] err_wide;
  logic [31:0] err_trunc;
  logic [31:0] err_mag;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pps_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pps_edge   = s2_q & ~s3_q;
  assign cnt_plus1  = cnt_q + 32'd1;
  assign at_timeout = (cnt_q == TimeoutM1);

  // Measurement FSM: next state and counter. An edge wins over a timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StAcq: begin
        if (pps_edge) begin
          cnt_d   = 32'd0;
          state_d = StMeas;
        end else if (at_timeout) begin
          state_d = StLost;
        end else begin
          cnt_d = cnt_plus1;
        end
      end
      StMeas: begin
        if (pps_edge) begin
          capture = 1'b1;
          cnt_d   = 32'd0;
        end else if (at_timeout) begin
          state_d = StLost;
        end else begin
          cnt_d = cnt_plus1;
        end
      end
      StLost: begin
        // First period after recovery is only armed, never captured.
        if (pps_edge) begin
          cnt_d   = 32'd0;
          state_d = StMeas;
        end
      end
      default: begin
        state_d = StAcq;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Error is formed in 33 bits and truncated; periods stay far below 2^31.
  always_comb begin
    err_wide  = {1'b0, cnt_plus1} - {1'b0, NOMINAL};
    err_trunc = err_wide[31:0];
    err_mag   = err_trunc[31] ? (~err_trunc + 32'd1) : err_trunc;
  end

  // Result registers load only on capture; handshake flags follow the ack rules.
  always_comb begin
    period_d   = period_q;
    freq_err_d = freq_err_q;
    in_tol_d   = in_tol_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (capture) begin
      period_d   = cnt_plus1;
      freq_err_d = err_trunc;
      in_tol_d   = (err_mag <= TOL);
      valid_d    = 1'b1;
      if (period_ack) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (period_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign lost_d = (state_d == StLost);

  // State, counter and output registers.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q    <= StAcq;
      cnt_q      <= 32'd0;
      period_q   <= 32'd0;
      freq_err_q <= 32'd0;
      in_tol_q   <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      freq_err_q <= freq_err_d;
      in_tol_q   <= in_tol_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      lost_q     <= lost_d;
    end
  end

  assign period       = period_q;
  assign freq_err     = freq_err_q;
  assign in_tol       = in_tol_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign pps_lost     = lost_q;

endmodule

// File: tb/tb_pps_period_meter.sv
// Directed bench for pps_period_meter with NOMINAL=100, TOL=2, TIMEOUT=150.
module tb_pps_period_meter;

  logic        clk;
  logic        rst_n;
  logic        pps;
  logic        ack;
  logic [31:0] period;
  logic [31:0] freq_err;
  logic        in_tol;
  logic        period_valid;
  logic        overrun;
  logic        pps_lost;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int last_raise = 0;
  int cap_cyc = 0;

  pps_period_meter #(
    .NOMINAL(100),
    .TOL    (2),
    .TIMEOUT(150)
  ) dut (
    .CLK_SYS     (clk),
    .CLK_RST     (rst_n),
    .pps_in      (pps),
    .period_ack  (ack),
    .period      (period),
    .freq_err    (freq_err),
    .in_tol      (in_tol),
    .period_valid(period_valid),
    .overrun     (overrun),
    .pps_lost    (pps_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise pps for 3 cycles; returns at the negedge after the capture edge.
  task automatic pulse(input bit ack_at_cap);
    last_raise = cyc;
    pps = 1'b1;
    tick(2);
    if (ack_at_cap) ack = 1'b1;
    tick(1);
    ack = 1'b0;
    pps = 1'b0;
    cap_cyc = cyc;
  endtask

  task automatic wait_gap(input int n);
    while (cyc < last_raise + n) tick(1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic chk_meas(input string tag, input logic [31:0] p, input logic [31:0] e,
                          input logic t, input logic v, input logic o);
    chk({tag, "_period"}, period, p);
    chk({tag, "_ferr"}, freq_err, e);
    chk({tag, "_intol"}, 32'(in_tol), 32'(t));
    chk({tag, "_valid"}, 32'(period_valid), 32'(v));
    chk({tag, "_ovr"}, 32'(overrun), 32'(o));
  endtask

  initial begin
    rst_n = 1'b0;
    pps   = 1'b0;
    ack   = 1'b0;
    tick(2);
    chk_meas("rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_lost", 32'(pps_lost), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // First edge only arms.
    pulse(1'b0);
    chk("arm_valid", 32'(period_valid), 32'd0);
    chk("arm_period", period, 32'd0);

    wait_gap(100);
    pulse(1'b0);
    chk_meas("p100", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    do_ack();
    chk("p100_ack_valid", 32'(period_valid), 32'd0);

    wait_gap(100);
    pulse(1'b0);
    chk_meas("p100b", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    do_ack();

    wait_gap(102);
    pulse(1'b0);
    chk_meas("p102", 32'd102, 32'd2, 1'b1, 1'b1, 1'b0);
    do_ack();

    wait_gap(103);
    pulse(1'b0);
    chk_meas("p103", 32'd103, 32'd3, 1'b0, 1'b1, 1'b0);
    do_ack();

    // Left unacknowledged so the next capture overruns.
    wait_gap(97);
    pulse(1'b0);
    chk_meas("p97", 32'd97, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);

    wait_gap(98);
    pulse(1'b0);
    chk_meas("p98_ovr", 32'd98, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    do_ack();
    chk("ovr_ack_valid", 32'(period_valid), 32'd0);
    chk("ovr_ack_ovr", 32'(overrun), 32'd0);

    wait_gap(100);
    pulse(1'b0);
    chk_meas("p100c", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    wait_gap(101);
    pulse(1'b0);
    chk_meas("p101_ovr", 32'd101, 32'd1, 1'b1, 1'b1, 1'b1);
    wait_gap(99);
    pulse(1'b1);
    chk_meas("p99_coack", 32'd99, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_ack();
    chk("coack_ack_valid", 32'(period_valid), 32'd0);

    // Pulses stop: loss 150 cycles after last detected edge.
    while (cyc < cap_cyc + 149) tick(1);
    chk("lost_149", 32'(pps_lost), 32'd0);
    tick(1);
    chk("lost_150", 32'(pps_lost), 32'd1);
    chk("lost_period_held", period, 32'd99);
    tick(20);

    pulse(1'b0);
    chk("recover_lost", 32'(pps_lost), 32'd0);
    chk("recover_valid", 32'(period_valid), 32'd0);
    chk("recover_period", period, 32'd99);
    wait_gap(100);
    pulse(1'b0);
    chk_meas("p100_rec", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    do_ack();

    // Held-high pulse yields a single edge.
    wait_gap(100);
    last_raise = cyc;
    pps = 1'b1;
    tick(3);
    chk_meas("hold_cap", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    tick(497);
    pps = 1'b0;
    chk("hold_lost", 32'(pps_lost), 32'd1);
    chk_meas("hold_end", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
    tick(5);

    // Reset 40 cycles into a measured period.
    pulse(1'b0);
    chk("rearm_lost", 32'(pps_lost), 32'd0);
    wait_gap(40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_meas("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst_lost", 32'(pps_lost), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    pulse(1'b0);
    chk("post_rst_arm_valid", 32'(period_valid), 32'd0);
    chk("post_rst_arm_period", period, 32'd0);
    wait_gap(100);
    pulse(1'b0);
    chk_meas("post_rst_p100", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);

    // No pulse after reset: loss at cycle 150.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(149);
    chk("acq_lost_149", 32'(pps_lost), 32'd0);
    tick(1);
    chk("acq_lost_150", 32'(pps_lost), 32'd1);
    chk("acq_lost_valid", 32'(period_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
